// File: rtl/i2c_eeprom_slave.sv
// I2C target that emulates a 24C02-style byte-addressed EEPROM (address match, word address, writes, reads).
// Latency: SCL/SDA are seen 3 CLK late through the synchronizers; SDA changes 1 CLK after a detected SCL fall.
// Backpressure: none; SCL is never stretched, so the master must keep SCL high and low for at least 8 CLK each.
//
// Ports:
//   CLK, RSTn          system clock, asynchronous active-low reset
//   SCL                I2C clock from the master (input only)
//   SDA                open-drain I2C data: driven 0 or released, never driven 1
//   Wr_Sig/Addr/Data   one-CLK strobe with the address and value of each byte committed to memory
//   Busy               high from the address-match ACK until STOP, a mismatching START, or reset

module i2c_eeprom_slave #(
    parameter logic [6:0] DEV_ADDR = 7'h50,
    parameter int         ADDR_W   = 8
) (
    input  logic              CLK,
    input  logic              RSTn,
    input  logic              SCL,
    inout  wire               SDA,
    output logic              Wr_Sig,
    output logic [ADDR_W-1:0] Wr_Addr,
    output logic [7:0]        Wr_Data,
    output logic              Busy
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [3:0] {
        S_IDLE,
        S_DEVADDR,
        S_ACK_DEV,
        S_WADDR,
        S_ACK_WADDR,
        S_WDATA,
        S_ACK_WDATA,
        S_RDATA,
        S_RACK
    } state_t;

    // Two synchronizer stages plus one history stage per line. These reset
    // high (idle bus) so leaving reset never looks like a START or STOP.
    logic scl_s1_q, scl_s2_q, scl_h_q;
    logic sda_s1_q, sda_s2_q, sda_h_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            scl_s1_q <= 1'b1;
            scl_s2_q <= 1'b1;
            scl_h_q  <= 1'b1;
            sda_s1_q <= 1'b1;
            sda_s2_q <= 1'b1;
            sda_h_q  <= 1'b1;
        end else begin
            scl_s1_q <= SCL;
            scl_s2_q <= scl_s1_q;
            scl_h_q  <= scl_s2_q;
            sda_s1_q <= SDA;
            sda_s2_q <= sda_s1_q;
            sda_h_q  <= sda_s2_q;
        end
    end

    logic scl_rise, scl_fall, start_det, stop_det;
    assign scl_rise  =  scl_s2_q & ~scl_h_q;
    assign scl_fall  = ~scl_s2_q &  scl_h_q;
    assign start_det =  scl_s2_q &  scl_h_q &  sda_h_q & ~sda_s2_q;
    assign stop_det  =  scl_s2_q &  scl_h_q & ~sda_h_q &  sda_s2_q;

    state_t            state_q,   state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q,   shift_d;
    logic [ADDR_W-1:0] ptr_q,     ptr_d;
    logic              sda_oe_q,  sda_oe_d;
    logic              busy_q,    busy_d;
    logic              ack_bit_q, ack_bit_d;
    logic              wr_sig_q,  wr_sig_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;

    logic [7:0]        mem_q [DEPTH];
    logic              mem_we;
    logic [7:0]        mem_wdata;

    logic [7:0]        shift_in;
    logic [7:0]        rd_byte;
    logic [ADDR_W-1:0] ptr_inc;

    assign shift_in = {shift_q[6:0], sda_s2_q};
    assign rd_byte  = mem_q[ptr_q];
    assign ptr_inc  = ptr_q + ADDR_W'(1);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q   <= S_IDLE;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            ack_bit_q <= 1'b1;
            wr_sig_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            ack_bit_q <= ack_bit_d;
            wr_sig_q  <= wr_sig_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Storage has no reset: contents stay undefined until written.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[ptr_q] <= mem_wdata;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        ack_bit_d = ack_bit_q;
        wr_sig_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_we    = 1'b0;
        mem_wdata = shift_in;

        if (start_det) begin
            // Busy survives a repeated START; only a mismatching address drops it.
            state_d   = S_DEVADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = S_IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    sda_oe_d = 1'b0;
                end

                S_DEVADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        if (shift_q[7:1] == DEV_ADDR) begin
                            state_d  = S_ACK_DEV;
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                        end else begin
                            state_d  = S_IDLE;
                            sda_oe_d = 1'b0;
                            busy_d   = 1'b0;
                        end
                    end
                end

                S_ACK_DEV: begin
                    // shift_q[0] still holds the R/W bit of the address byte.
                    if (scl_fall) begin
                        if (shift_q[0]) begin
                            state_d  = S_RDATA;
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = S_WADDR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                S_WADDR: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        ptr_d     = shift_q[ADDR_W-1:0];
                        state_d   = S_ACK_WADDR;
                        sda_oe_d  = 1'b1;
                    end
                end

                S_ACK_WADDR: begin
                    if (scl_fall) begin
                        state_d  = S_WDATA;
                        sda_oe_d = 1'b0;
                    end
                end

                S_WDATA: begin
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        // Commit on the 8th sampled bit; a START/STOP can only
                        // discard a byte that has not reached this point.
                        if (bit_cnt_q == 4'd7) begin
                            mem_we    = 1'b1;
                            wr_sig_d  = 1'b1;
                            wr_addr_d = ptr_q;
                            wr_data_d = shift_in;
                            ptr_d     = ptr_inc;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        state_d   = S_ACK_WDATA;
                        sda_oe_d  = 1'b1;
                    end
                end

                S_ACK_WDATA: begin
                    if (scl_fall) begin
                        state_d  = S_WDATA;
                        sda_oe_d = 1'b0;
                    end
                end

                S_RDATA: begin
                    // Bit 7 is already on the line on entry; each later fall
                    // presents the next bit, and the fall after bit 0 releases.
                    if (scl_rise && bit_cnt_q < 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        bit_cnt_d = 4'd0;
                        ptr_d     = ptr_inc;
                        sda_oe_d  = 1'b0;
                        ack_bit_d = 1'b1;
                        state_d   = S_RACK;
                    end else if (scl_fall && bit_cnt_q != 4'd0) begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end

                S_RACK: begin
                    if (scl_rise) begin
                        ack_bit_d = sda_s2_q;
                    end else if (scl_fall) begin
                        if (!ack_bit_q) begin
                            state_d  = S_RDATA;
                            shift_d  = rd_byte;
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            // Master NACK ends the read; Busy waits for STOP.
                            state_d  = S_IDLE;
                            sda_oe_d = 1'b0;
                        end
                    end
                end

                default: begin
                    state_d  = S_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // RSTn gates the driver directly so the line is freed without waiting for a clock.
    assign SDA     = (sda_oe_q && RSTn) ? 1'b0 : 1'bz;
    assign Wr_Sig  = wr_sig_q;
    assign Wr_Addr = wr_addr_q;
    assign Wr_Data = wr_data_q;
    assign Busy    = busy_q;

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
// Bench for i2c_eeprom_slave: bit-level I2C master, directed vector table,
// randomized transactions against a byte-array model, and abort/reset corner sequences.
module tb_i2c_eeprom_slave;

    localparam int OP_WR  = 0;
    localparam int OP_RR  = 1;
    localparam int OP_CR  = 2;
    localparam int OP_BAD = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl = 1'b1;
    logic       sda_drv_lo = 1'b0;
    wire        sda;
    logic       wr_sig;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    pullup (sda);
    assign sda = sda_drv_lo ? 1'b0 : 1'bz;

    always #10 clk = ~clk;

    i2c_eeprom_slave #(.DEV_ADDR(7'h50), .ADDR_W(8)) dut (
        .CLK     (clk),
        .RSTn    (rst_n),
        .SCL     (scl),
        .SDA     (sda),
        .Wr_Sig  (wr_sig),
        .Wr_Addr (wr_addr),
        .Wr_Data (wr_data),
        .Busy    (busy)
    );

    typedef struct packed { logic [7:0] a; logic [7:0] d; } wr_t;
    wr_t wr_log[$];
    wr_t wr_exp[$];

    always @(negedge clk) begin
        if (wr_sig) wr_log.push_back({wr_addr, wr_data});
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: flat byte array with a persistent wrapping pointer.
    logic [7:0] m_mem [256];
    bit         m_vld [256];
    logic [7:0] m_ptr = 8'h00;

    function automatic void m_write(input logic [7:0] d);
        m_mem[m_ptr] = d;
        m_vld[m_ptr] = 1'b1;
        wr_exp.push_back({m_ptr, d});
        m_ptr = m_ptr + 8'd1;
    endfunction

    // ---------------- bit-level master ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_drv_lo = 1'b0; tick(8);
        scl = 1'b1;        tick(10);
        sda_drv_lo = 1'b1; tick(10);
        scl = 1'b0;        tick(2);
    endtask

    task automatic bus_stop();
        tick(2);
        sda_drv_lo = 1'b1; tick(8);
        scl = 1'b1;        tick(10);
        sda_drv_lo = 1'b0; tick(10);
    endtask

    task automatic put_bit(input logic b);
        tick(2);
        sda_drv_lo = ~b; tick(8);
        scl = 1'b1;      tick(10);
        scl = 1'b0;
    endtask

    task automatic get_bit(output logic b);
        tick(2);
        sda_drv_lo = 1'b0; tick(8);
        scl = 1'b1;        tick(8);
        b = sda;           tick(2);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic bv;
        for (int i = 7; i >= 0; i--) put_bit(b[i]);
        get_bit(bv);
        ack = ~bv;
    endtask

    task automatic recv_byte(output logic [7:0] b, input logic ack);
        logic bv;
        for (int i = 7; i >= 0; i--) begin
            get_bit(bv);
            b[i] = bv;
        end
        put_bit(~ack);
    endtask

    // ---------------- transactions ----------------
    task automatic do_write(input logic [7:0] addr, input int n, input logic [0:3][7:0] d,
                            output logic acks, output logic busy_mid);
        logic a;
        acks = 1'b1;
        bus_start();
        send_byte(8'hA0, a); acks &= a;
        send_byte(addr, a);  acks &= a;
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], a); acks &= a;
        end
        busy_mid = busy;
        bus_stop();
    endtask

    task automatic do_read(input logic random, input logic [7:0] addr, input int n,
                           output logic [0:3][7:0] rd, output logic acks, output logic busy_mid);
        logic       a;
        logic [7:0] b;
        acks = 1'b1;
        rd   = '0;
        bus_start();
        if (random) begin
            send_byte(8'hA0, a); acks &= a;
            send_byte(addr, a);  acks &= a;
            bus_start();
        end
        send_byte(8'hA1, a); acks &= a;
        for (int i = 0; i < n; i++) begin
            recv_byte(b, i != n - 1);
            rd[i] = b;
        end
        busy_mid = busy;
        bus_stop();
    endtask

    task automatic do_bad(input logic [7:0] dev, output logic ack, output logic busy_mid);
        bus_start();
        send_byte(dev, ack);
        busy_mid = busy;
        bus_stop();
    endtask

    task automatic check_wr_log(input string name);
        chk({name, " wr count"}, 16'(wr_log.size()), 16'(wr_exp.size()));
        for (int i = 0; i < wr_exp.size() && i < wr_log.size(); i++)
            chk({name, " wr entry"}, wr_log[i], wr_exp[i]);
        wr_log.delete();
        wr_exp.delete();
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        int              op;
        logic [7:0]      dev;
        logic [7:0]      addr;
        int              n;
        logic [0:3][7:0] d;
        logic            exp_ack;
        logic [0:3][7:0] e;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    initial begin
        vec_t            t;
        logic            acks, bm, a;
        logic [0:3][7:0] rd;
        logic [0:3][7:0] rdat;
        logic [7:0]      addr, dev;
        int              op, n;

        vecs[0] = '{OP_WR,  8'hA0, 8'h00, 1, {8'h12, 8'h00, 8'h00, 8'h00}, 1'b1, '0};
        vecs[1] = '{OP_RR,  8'hA0, 8'h00, 1, '0, 1'b1, {8'h12, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{OP_WR,  8'hA0, 8'hFF, 3, {8'hAA, 8'hBB, 8'hCC, 8'h00}, 1'b1, '0};
        vecs[3] = '{OP_RR,  8'hA0, 8'hFF, 2, '0, 1'b1, {8'hAA, 8'hBB, 8'h00, 8'h00}};
        vecs[4] = '{OP_BAD, 8'hA2, 8'h00, 0, '0, 1'b0, '0};
        vecs[5] = '{OP_CR,  8'hA1, 8'h00, 1, '0, 1'b1, {8'hCC, 8'h00, 8'h00, 8'h00}};
        vecs[6] = '{OP_WR,  8'hA0, 8'h05, 1, {8'h5A, 8'h00, 8'h00, 8'h00}, 1'b1, '0};

        // Reset state
        tick(5);
        chk("reset sda",     {15'd0, sda},  16'h1);
        chk("reset wr_sig",  {15'd0, wr_sig}, 16'h0);
        chk("reset wr_addr", {8'd0, wr_addr}, 16'h0);
        chk("reset wr_data", {8'd0, wr_data}, 16'h0);
        chk("reset busy",    {15'd0, busy}, 16'h0);
        rst_n = 1'b1;
        tick(5);

        for (int v = 0; v < NV; v++) begin
            t = vecs[v];
            rd = '0;
            case (t.op)
                OP_WR: begin
                    do_write(t.addr, t.n, t.d, acks, bm);
                    m_ptr = t.addr;
                    for (int i = 0; i < t.n; i++) m_write(t.d[i]);
                end
                OP_RR, OP_CR: begin
                    do_read(t.op == OP_RR, t.addr, t.n, rd, acks, bm);
                    if (t.op == OP_RR) m_ptr = t.addr;
                    for (int i = 0; i < t.n; i++) begin
                        chk($sformatf("vec%0d rdata%0d", v, i), {8'd0, rd[i]}, {8'd0, t.e[i]});
                        m_ptr = m_ptr + 8'd1;
                    end
                end
                default: begin
                    do_bad(t.dev, acks, bm);
                end
            endcase
            tick(4);
            chk($sformatf("vec%0d ack", v),       {15'd0, acks}, {15'd0, t.exp_ack});
            chk($sformatf("vec%0d busy_mid", v),  {15'd0, bm},   {15'd0, t.exp_ack});
            chk($sformatf("vec%0d busy_stop", v), {15'd0, busy}, 16'h0);
            check_wr_log($sformatf("vec%0d", v));
        end

        // Abort mid-byte: STOP after 4 data bits discards the byte.
        bus_start();
        send_byte(8'hA0, a);
        send_byte(8'h05, a);
        chk("abort busy", {15'd0, busy}, 16'h1);
        put_bit(1'b1); put_bit(1'b1); put_bit(1'b0); put_bit(1'b0);
        bus_stop();
        tick(4);
        chk("abort busy_stop", {15'd0, busy}, 16'h0);
        m_ptr = 8'h05;
        check_wr_log("abort");
        do_read(1'b0, 8'h00, 1, rd, acks, bm);
        chk("abort cur read", {8'd0, rd[0]}, 16'h005A);
        chk("abort cur ack", {15'd0, acks}, 16'h1);
        m_ptr = m_ptr + 8'd1;

        // Randomized transactions against the model (window wraps across 0xFF/0x00).
        for (int k = 0; k < 12; k++) begin
            op   = $urandom_range(0, 3);
            addr = 8'hFC + 8'($urandom_range(0, 7));
            n    = $urandom_range(1, 3);
            for (int i = 0; i < 4; i++) rdat[i] = 8'($urandom);
            case (op)
                OP_WR: begin
                    do_write(addr, n, rdat, acks, bm);
                    m_ptr = addr;
                    for (int i = 0; i < n; i++) m_write(rdat[i]);
                end
                OP_RR, OP_CR: begin
                    do_read(op == OP_RR, addr, n, rd, acks, bm);
                    if (op == OP_RR) m_ptr = addr;
                    for (int i = 0; i < n; i++) begin
                        if (m_vld[m_ptr])
                            chk($sformatf("rnd%0d rdata%0d", k, i), {8'd0, rd[i]}, {8'd0, m_mem[m_ptr]});
                        m_ptr = m_ptr + 8'd1;
                    end
                end
                default: begin
                    do dev = 8'($urandom_range(0, 255)); while (dev[7:1] == 7'h50);
                    do_bad(dev, acks, bm);
                end
            endcase
            tick(4);
            chk($sformatf("rnd%0d ack", k), {15'd0, acks}, (op == OP_BAD) ? 16'h0 : 16'h1);
            chk($sformatf("rnd%0d busy_mid", k), {15'd0, bm}, (op == OP_BAD) ? 16'h0 : 16'h1);
            chk($sformatf("rnd%0d busy_stop", k), {15'd0, busy}, 16'h0);
            check_wr_log($sformatf("rnd%0d", k));
        end

        // Reset while the target is driving a 0 data bit.
        rdat = {8'h3C, 8'h00, 8'h00, 8'h00};
        do_write(8'h00, 1, rdat, acks, bm);
        m_ptr = 8'h00;
        m_write(8'h3C);
        check_wr_log("pre-reset");
        bus_start();
        send_byte(8'hA0, a);
        send_byte(8'h00, a);
        bus_start();
        send_byte(8'hA1, a);
        tick(6);
        chk("rd bit7 driven low", {15'd0, sda}, 16'h0);
        chk("rd busy", {15'd0, busy}, 16'h1);
        #3 rst_n = 1'b0;
        #1;
        chk("rst sda released", {15'd0, sda}, 16'h1);
        chk("rst wr_sig",  {15'd0, wr_sig}, 16'h0);
        chk("rst wr_addr", {8'd0, wr_addr}, 16'h0);
        chk("rst wr_data", {8'd0, wr_data}, 16'h0);
        chk("rst busy",    {15'd0, busy}, 16'h0);
        tick(3);
        rst_n = 1'b1;
        scl   = 1'b1;
        tick(20);
        m_ptr = 8'h00;
        do_read(1'b0, 8'h00, 1, rd, acks, bm);
        chk("post-reset cur read", {8'd0, rd[0]}, {8'd0, m_mem[8'h00]});
        chk("post-reset ack", {15'd0, acks}, 16'h1);
        check_wr_log("post-reset");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
